// File: rtl/mux8_sel_reg.sv
// rtl/mux8_sel_reg.sv - 8-to-1 lane selector with combinational and registered outputs (optional y_par via MUX8_OUT_PARITY_EN)
module mux8_sel_reg #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*WIDTH-1:0] in,
  input  logic [2:0]         sel,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   y_comb,
  output logic [WIDTH-1:0]   y,
`ifdef MUX8_OUT_PARITY_EN
  output logic               y_par,
`endif
  output logic               out_valid
);

  // Unpacked view of the packed input bus; lane 0 sits at the LSBs.
  logic [WIDTH-1:0] lanes [8];

  // Slice the packed bus into lanes so the select below is a plain index.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      lanes[k] = in[k*WIDTH +: WIDTH];
    end
  end

  // Full case on sel: every code maps to a lane, so only the chosen lane can reach y_comb.
  always_comb begin
    y_comb = '0;
    case (sel)
      3'd0: y_comb = lanes[0];
      3'd1: y_comb = lanes[1];
      3'd2: y_comb = lanes[2];
      3'd3: y_comb = lanes[3];
      3'd4: y_comb = lanes[4];
      3'd5: y_comb = lanes[5];
      3'd6: y_comb = lanes[6];
      3'd7: y_comb = lanes[7];
      default: y_comb = 'x;
    endcase
  end

  // Capture register: reset wins, a valid beat loads the selected lane, otherwise y holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y <= y_comb;
      end
    end
  end

`ifdef MUX8_OUT_PARITY_EN
  // Even parity of the captured lane, loaded on the same beats as y.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_par <= 1'b0;
    end else if (in_valid) begin
      y_par <= ^y_comb;
    end
  end
`endif

endmodule

// File: tb/tb_mux8_sel_reg.sv
// tb/tb_mux8_sel_reg.sv - directed self-checking bench for mux8_sel_reg
module tb_mux8_sel_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in1;
  logic [63:0] in8;
  logic [2:0]  sel;
  logic        in_valid;
  logic        y_comb1, y1, ov1;
  logic [7:0]  y_comb8, y8;
  logic        ov8;
`ifdef MUX8_OUT_PARITY_EN
  logic        y_par1, y_par8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux8_sel_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .sel(sel), .in_valid(in_valid),
    .y_comb(y_comb1), .y(y1),
`ifdef MUX8_OUT_PARITY_EN
    .y_par(y_par1),
`endif
    .out_valid(ov1)
  );

  mux8_sel_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in(in8), .sel(sel), .in_valid(in_valid),
    .y_comb(y_comb8), .y(y8),
`ifdef MUX8_OUT_PARITY_EN
    .y_par(y_par8),
`endif
    .out_valid(ov8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sel = 3'd0;
    in1 = 8'b1010_1111;
    in8 = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    tick(); tick();
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL reset_y1 got %b exp 0", y1); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1 got %b exp 0", ov1); end
    checks++; if (y8 !== 8'h00) begin errors++; $display("FAIL reset_y8 got %h exp 00", y8); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_ov8 got %b exp 0", ov8); end
`ifdef MUX8_OUT_PARITY_EN
    checks++; if (y_par8 !== 1'b0) begin errors++; $display("FAIL reset_par8 got %b exp 0", y_par8); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_comb_sweep();
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_1111;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #10;
      checks++;
      if (y_comb1 !== exp_bits[i]) begin
        errors++; $display("FAIL comb_sel%0d got %b exp %b", i, y_comb1, exp_bits[i]);
      end
    end
  endtask

  task automatic test_registered();
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_1111;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick();
      checks++;
      if (y1 !== exp_bits[i]) begin
        errors++; $display("FAIL reg_y_sel%0d got %b exp %b", i, y1, exp_bits[i]);
      end
      checks++;
      if (ov1 !== 1'b1) begin
        errors++; $display("FAIL reg_ov_sel%0d got %b exp 1", i, ov1);
      end
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b1; sel = 3'd4;
    tick();
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL hold_cap got %b exp 0", y1); end
    in_valid = 1'b0; sel = 3'd0;
    #1;
    checks++; if (y_comb1 !== 1'b1) begin errors++; $display("FAIL hold_comb got %b exp 1", y_comb1); end
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL hold_y_pre got %b exp 0", y1); end
    tick();
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL hold_y got %b exp 0", y1); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL hold_ov got %b exp 0", ov1); end
    checks++; if (y8 !== 8'h44) begin errors++; $display("FAIL hold_y8 got %h exp 44", y8); end
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; sel = 3'd1;
    tick();
    checks++; if (y1 !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", y1); end
    rst = 1'b1; sel = 3'd0;
    tick();
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL midrst_y got %b exp 0", y1); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL midrst_ov got %b exp 0", ov1); end
    checks++; if (y8 !== 8'h00) begin errors++; $display("FAIL midrst_y8 got %h exp 00", y8); end
    rst = 1'b0;
    tick();
    checks++; if (y1 !== 1'b1) begin errors++; $display("FAIL postrst_y got %b exp 1", y1); end
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL postrst_ov got %b exp 1", ov1); end
  endtask

  task automatic test_width8();
    in_valid = 1'b1; sel = 3'd5;
    #1;
    checks++; if (y_comb8 !== 8'h55) begin errors++; $display("FAIL w8_comb got %h exp 55", y_comb8); end
    tick();
    checks++; if (y8 !== 8'h55) begin errors++; $display("FAIL w8_y got %h exp 55", y8); end
    checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL w8_ov got %b exp 1", ov8); end
`ifdef MUX8_OUT_PARITY_EN
    checks++; if (y_par8 !== 1'b0) begin errors++; $display("FAIL w8_par55 got %b exp 0", y_par8); end
`endif
    sel = 3'd7;
    tick();
    checks++; if (y8 !== 8'h77) begin errors++; $display("FAIL w8_y7 got %h exp 77", y8); end
    sel = 3'd0;
    tick();
    checks++; if (y8 !== 8'h00) begin errors++; $display("FAIL w8_y0 got %h exp 00", y8); end
    in8[31:24] = 8'h07; sel = 3'd3;
    tick();
    checks++; if (y8 !== 8'h07) begin errors++; $display("FAIL w8_y07 got %h exp 07", y8); end
`ifdef MUX8_OUT_PARITY_EN
    checks++; if (y_par8 !== 1'b1) begin errors++; $display("FAIL w8_par07 got %b exp 1", y_par8); end
    in_valid = 1'b0; sel = 3'd5;
    tick();
    checks++; if (y_par8 !== 1'b1) begin errors++; $display("FAIL w8_parhold got %b exp 1", y_par8); end
`endif
    in_valid = 1'b0;
    tick();
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL w8_ov_drop got %b exp 0", ov8); end
  endtask

  initial begin
    test_reset();
    test_comb_sweep();
    test_registered();
    test_hold();
    test_mid_reset();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
